// File: rtl/bcd_clock_core.sv
// rtl/bcd_clock_core.sv - parametrised BCD clock core: up/down count, UART command decode, staged digit loads
// Optional alarm (register, ALOAD state, 'A' command, alarm_hit) is built when BCD_CLOCK_ALARM_EN is defined.
module bcd_clock_core #(
    parameter int NFIELDS   = 2,
    parameter int TOP_MAX   = 59,
    parameter int LOWER_MAX = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data_rdy,
    input  logic [7:0]           rx_data,
    input  logic                 sec_strb,
    output logic [8*NFIELDS-1:0] digits,
    output logic [8*NFIELDS-1:0] alarm_digits,
    output logic                 running,
    output logic                 count_down,
    output logic                 load_active,
    output logic [2:0]           load_idx,
    output logic                 zero_hit,
    output logic                 alarm_hit
);
    localparam int         W          = 8 * NFIELDS;
    localparam int         LAST       = 2 * NFIELDS - 1;
    localparam logic [2:0] COMMIT_IDX = 3'(2 * NFIELDS);
    localparam logic [7:0] TOP_BCD    = 8'((TOP_MAX / 10) * 16 + TOP_MAX % 10);
    localparam logic [7:0] LOW_BCD    = 8'((LOWER_MAX / 10) * 16 + LOWER_MAX % 10);

    typedef enum logic [1:0] {
        S_RUN,
        S_STOP,
        S_TLOAD
`ifdef BCD_CLOCK_ALARM_EN
        , S_ALOAD
`endif
    } state_t;

    state_t         state, state_n;
    logic           pre_run, pre_run_n;
    logic           count_down_n;
    logic [W-1:0]   digits_n;
    logic [W-1:0]   shadow, shadow_n;
    logic [2:0]     load_idx_n;
    logic           zero_hit_n;
    logic [W-1:0]   stepped;
    logic [7:0]     fld, fmax;
    logic           carry;
    logic           do_step;
    logic [7:0]     cmd;
    logic           is_digit, digit_ok;
    logic [3:0]     prev_tens;
    logic [7:0]     lim;
`ifdef BCD_CLOCK_ALARM_EN
    logic [W-1:0]   alarm_q, alarm_n;
    logic           step_q;
`endif

    assign cmd         = rx_data | 8'h20;  // fold letters to lower case
    assign load_active = (state != S_RUN) && (state != S_STOP);
    assign running     = (state == S_RUN) || (load_active && pre_run);
    assign do_step     = (state == S_RUN) && sec_strb && !(count_down && digits == '0);

    // One count step with ripple carry/borrow from the least significant field.
    always_comb begin
        stepped = digits;
        carry   = 1'b1;
        fld     = 8'h00;
        fmax    = 8'h00;
        for (int j = 0; j < NFIELDS; j++) begin
            fld  = digits[8*j +: 8];
            fmax = (j == NFIELDS - 1) ? TOP_BCD : LOW_BCD;
            if (carry) begin
                if (!count_down) begin
                    if (fld == fmax) begin
                        fld = 8'h00;
                    end else if (fld[3:0] == 4'd9) begin
                        fld   = {fld[7:4] + 4'd1, 4'd0};
                        carry = 1'b0;
                    end else begin
                        fld[3:0] = fld[3:0] + 4'd1;
                        carry    = 1'b0;
                    end
                end else begin
                    if (fld == 8'h00) begin
                        fld = fmax;
                    end else if (fld[3:0] == 4'd0) begin
                        fld   = {fld[7:4] - 4'd1, 4'd9};
                        carry = 1'b0;
                    end else begin
                        fld[3:0] = fld[3:0] - 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
            stepped[8*j +: 8] = fld;
        end
    end

    // Range check of the incoming load digit against its field limit.
    always_comb begin
        is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        prev_tens = 4'd0;
        for (int k = 0; k < 2 * NFIELDS; k += 2) begin
            if (int'(load_idx) == k + 1) prev_tens = shadow[(LAST - k) * 4 +: 4];
        end
        lim = (load_idx < 3'd2) ? TOP_BCD : LOW_BCD;
        if (!load_idx[0]) digit_ok = (rx_data[3:0] <= lim[7:4]);
        else              digit_ok = ({prev_tens, rx_data[3:0]} <= lim);
    end

    always_comb begin
        state_n      = state;
        pre_run_n    = pre_run;
        count_down_n = count_down;
        digits_n     = digits;
        shadow_n     = shadow;
        load_idx_n   = load_idx;
        zero_hit_n   = 1'b0;
`ifdef BCD_CLOCK_ALARM_EN
        alarm_n      = alarm_q;
`endif
        if (do_step) begin
            digits_n = stepped;
            if (count_down && stepped == '0) begin
                zero_hit_n = 1'b1;
                state_n    = S_STOP;
            end
        end
        case (state)
            S_RUN, S_STOP: begin
                if (rx_data_rdy) begin
                    case (cmd)
                        8'h72: state_n = S_RUN;
                        8'h73: state_n = S_STOP;
                        8'h75: count_down_n = 1'b0;
                        8'h64: count_down_n = 1'b1;
                        8'h6c: begin
                            pre_run_n = (state_n == S_RUN);
                            state_n   = S_TLOAD;
                        end
`ifdef BCD_CLOCK_ALARM_EN
                        8'h61: begin
                            pre_run_n = (state_n == S_RUN);
                            state_n   = S_ALOAD;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: begin
                // load_idx past the last digit marks the commit cycle
                if (load_idx == COMMIT_IDX) begin
`ifdef BCD_CLOCK_ALARM_EN
                    if (state == S_ALOAD) alarm_n  = shadow;
                    else                  digits_n = shadow;
`else
                    digits_n = shadow;
`endif
                    shadow_n   = '0;
                    load_idx_n = 3'd0;
                    state_n    = pre_run ? S_RUN : S_STOP;
                end else if (rx_data_rdy) begin
                    if (is_digit && digit_ok) begin
                        for (int k = 0; k < 2 * NFIELDS; k++) begin
                            if (int'(load_idx) == k) shadow_n[(LAST - k) * 4 +: 4] = rx_data[3:0];
                        end
                        load_idx_n = load_idx + 3'd1;
                    end else begin
                        shadow_n   = '0;
                        load_idx_n = 3'd0;
                        state_n    = pre_run ? S_RUN : S_STOP;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            pre_run    <= 1'b1;
            count_down <= 1'b0;
            digits     <= '0;
            shadow     <= '0;
            load_idx   <= 3'd0;
            zero_hit   <= 1'b0;
        end else begin
            state      <= state_n;
            pre_run    <= pre_run_n;
            count_down <= count_down_n;
            digits     <= digits_n;
            shadow     <= shadow_n;
            load_idx   <= load_idx_n;
            zero_hit   <= zero_hit_n;
        end
    end

`ifdef BCD_CLOCK_ALARM_EN
    // alarm_hit trails the step that produced the match by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_q   <= '0;
            step_q    <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            alarm_q   <= alarm_n;
            step_q    <= do_step;
            alarm_hit <= step_q && (digits == alarm_q) && (alarm_q != '0);
        end
    end
    assign alarm_digits = alarm_q;
`else
    assign alarm_digits = '0;
    assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_clock_core.sv
// tb/tb_bcd_clock_core.sv - randomized bench for bcd_clock_core against a mixed-radix seconds model
module tb_bcd_clock_core;
    localparam int N      = 2;
    localparam int TOP    = 59;
    localparam int LOW    = 59;
    localparam int PERIOD = (TOP + 1) * (LOW + 1);
`ifdef BCD_CLOCK_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_data_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        sec_strb = 1'b0;
    logic [15:0] digits, alarm_digits;
    logic        running, count_down, load_active, zero_hit, alarm_hit;
    logic [2:0]  load_idx;

    logic        rx2_rdy = 1'b0;
    logic [7:0]  rx2_data = 8'h00;
    logic        sec2_strb = 1'b0;
    logic [23:0] digits2, alarm2;
    logic        running2, down2, active2, zero2, ahit2;
    logic [2:0]  idx2;

    int checks = 0;
    int failures = 0;
    int zh_cnt = 0;
    int ah_cnt = 0;

    int m_t, m_alarm, m_idx, m_load;
    bit m_run, m_down, m_zhit, m_ahit, m_ahit_nx;
    int m_sh [6];

    always #5 clk = ~clk;

    bcd_clock_core dut (
        .clk(clk), .rst(rst), .rx_data_rdy(rx_data_rdy), .rx_data(rx_data), .sec_strb(sec_strb),
        .digits(digits), .alarm_digits(alarm_digits), .running(running), .count_down(count_down),
        .load_active(load_active), .load_idx(load_idx), .zero_hit(zero_hit), .alarm_hit(alarm_hit)
    );

    bcd_clock_core #(.NFIELDS(3), .TOP_MAX(23), .LOWER_MAX(59)) dut3 (
        .clk(clk), .rst(rst), .rx_data_rdy(rx2_rdy), .rx_data(rx2_data), .sec_strb(sec2_strb),
        .digits(digits2), .alarm_digits(alarm2), .running(running2), .count_down(down2),
        .load_active(active2), .load_idx(idx2), .zero_hit(zero2), .alarm_hit(ahit2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int t);
        int v, f, rad;
        logic [31:0] r;
        v = t;
        r = '0;
        for (int j = 0; j < N; j++) begin
            rad = (j == N - 1) ? TOP + 1 : LOW + 1;
            f = v % rad;
            v = v / rad;
            r[8*j +: 8] = {4'(f / 10), 4'(f % 10)};
        end
        return r;
    endfunction

    function automatic int sh_value();
        int t;
        t = 0;
        for (int k = 0; k < N; k++)
            t = t * ((k == 0) ? TOP + 1 : LOW + 1) + m_sh[2*k] * 10 + m_sh[2*k+1];
        return t;
    endfunction

    task automatic model_reset();
        m_t = 0; m_alarm = 0; m_idx = 0; m_load = 0;
        m_run = 1; m_down = 0; m_zhit = 0; m_ahit = 0; m_ahit_nx = 0;
    endtask

    task automatic model_step(input bit rdy, input logic [7:0] b, input bit st);
        logic [7:0] c;
        int d, mx;
        bit stepped;
        m_zhit = 0;
        m_ahit = m_ahit_nx;
        m_ahit_nx = 0;
        stepped = 0;
        c = (b >= "a" && b <= "z") ? b - 8'h20 : b;
        if (m_load != 0) begin
            if (m_idx == 2 * N) begin
                if (m_load == 1) m_t = sh_value();
                else             m_alarm = sh_value();
                m_load = 0;
                m_idx = 0;
            end else if (rdy) begin
                d = int'(b) - 48;
                mx = (m_idx < 2) ? TOP : LOW;
                if (d >= 0 && d <= 9 &&
                    ((m_idx % 2 == 0) ? (d <= mx / 10) : (m_sh[m_idx-1] * 10 + d <= mx))) begin
                    m_sh[m_idx] = d;
                    m_idx++;
                end else begin
                    m_load = 0;
                    m_idx = 0;
                end
            end
        end else begin
            if (st && m_run) begin
                if (!m_down) begin
                    m_t = (m_t + 1) % PERIOD;
                    stepped = 1;
                end else if (m_t > 0) begin
                    m_t--;
                    stepped = 1;
                    if (m_t == 0) begin
                        m_zhit = 1;
                        m_run = 0;
                    end
                end
                if (ALARM && stepped && m_alarm != 0 && m_t == m_alarm) m_ahit_nx = 1;
            end
            if (rdy) begin
                case (c)
                    "R": m_run = 1;
                    "S": m_run = 0;
                    "U": m_down = 0;
                    "D": m_down = 1;
                    "L": begin m_load = 1; m_idx = 0; end
                    "A": if (ALARM) begin m_load = 2; m_idx = 0; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        check_eq("digits", digits, to_bcd(m_t));
        check_eq("alarm_digits", alarm_digits, ALARM ? to_bcd(m_alarm) : 32'd0);
        check_eq("running", running, m_run);
        check_eq("count_down", count_down, m_down);
        check_eq("load_active", load_active, m_load != 0);
        check_eq("load_idx", load_idx, m_idx);
        check_eq("zero_hit", zero_hit, m_zhit);
        check_eq("alarm_hit", alarm_hit, m_ahit);
    endtask

    task automatic cycle(input bit rdy, input logic [7:0] b, input bit st);
        rx_data_rdy = rdy;
        rx_data = b;
        sec_strb = st;
        @(posedge clk);
        #1;
        rx_data_rdy = 1'b0;
        sec_strb = 1'b0;
        model_step(rdy, b, st);
        if (zero_hit) zh_cnt++;
        if (alarm_hit) ah_cnt++;
        compare_all();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], 1'b0);
    endtask

    task automatic cycle3(input bit rdy, input logic [7:0] b, input bit st);
        rx2_rdy = rdy;
        rx2_data = b;
        sec2_strb = st;
        @(posedge clk);
        #1;
        rx2_rdy = 1'b0;
        sec2_strb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        compare_all();
    endtask

    function automatic int gen_max(input int idx);
        int mx;
        mx = (idx < 2) ? TOP : LOW;
        if (idx >= 2 * N) return 9;
        if (idx % 2 == 0) return mx / 10;
        return (m_sh[idx-1] == mx / 10) ? mx % 10 : 9;
    endfunction

    function automatic logic [7:0] pick_cmd();
        string tbl;
        tbl = "RSUDLArsudlaRRD";
        if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
        return tbl[$urandom_range(0, tbl.len() - 1)];
    endfunction

    initial begin
        int r, d, z0, a0;
        logic [7:0] b;

        do_reset();

        // three-field 24-hour instance
        send_str("");
        for (int i = 0; i < 7; i++) begin
            string s3;
            s3 = "L235959";
            cycle3(1'b1, s3[i], 1'b0);
        end
        cycle3(1'b0, 8'h00, 1'b0);
        check_eq("n3_load", digits2, 24'h235959);
        check_eq("n3_running", running2, 1'b1);
        cycle3(1'b0, 8'h00, 1'b1);
        check_eq("n3_wrap", digits2, 24'h000000);
        cycle3(1'b1, "L", 1'b0);
        cycle3(1'b1, "2", 1'b0);
        check_eq("n3_idx1", idx2, 3'd1);
        cycle3(1'b1, "4", 1'b0);
        check_eq("n3_abort_active", active2, 1'b0);
        check_eq("n3_abort_idx", idx2, 3'd0);
        check_eq("n3_abort_digits", digits2, 24'h000000);
        do_reset();

        // 60 seconds up
        for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00, 1'b1);
        check_eq("sixty", digits, 16'h0100);
        check_eq("sixty_zero_hit", zh_cnt, 0);

        // full load then wrap
        send_str("L5959");
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("load5959", digits, 16'h5959);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("wrap", digits, 16'h0000);

        // aborted loads
        cycle(1'b1, "L", 1'b0);
        check_eq("abort_enter", load_active, 1'b1);
        cycle(1'b1, "6", 1'b0);
        check_eq("abort6_active", load_active, 1'b0);
        check_eq("abort6_digits", digits, 16'h0000);
        send_str("L12x");
        check_eq("abortx_active", load_active, 1'b0);
        check_eq("abortx_digits", digits, 16'h0000);

        // count down to zero
        send_str("L0003");
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, "D", 1'b0);
        z0 = zh_cnt;
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("down2", digits, 16'h0002);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("down1", digits, 16'h0001);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("down0", digits, 16'h0000);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("down_hold", digits, 16'h0000);
        check_eq("down_zero_pulses", zh_cnt - z0, 1);
        check_eq("down_stopped", running, 1'b0);

        // alarm at 00:05
        send_str("A0005");
        cycle(1'b0, 8'h00, 1'b0);
        send_str("UL0000");
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, "r", 1'b0);
        a0 = ah_cnt;
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        check_eq("alarm_reach", digits, 16'h0005);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("alarm_pulses", ah_cnt - a0, ALARM ? 1 : 0);
        check_eq("alarm_value", alarm_digits, ALARM ? 16'h0005 : 16'h0000);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (m_load != 0 && r < 70) begin
                if ($urandom_range(0, 9) == 0) begin
                    b = 8'($urandom_range(0, 255));
                end else begin
                    d = $urandom_range(0, 1) ? 0 : $urandom_range(0, gen_max(m_idx));
                    b = 8'(48 + d);
                end
                cycle(1'b1, b, $urandom_range(0, 3) == 0);
            end else if (r < 45) begin
                cycle($urandom_range(0, 9) == 0, pick_cmd(), 1'b1);
            end else if (r < 75) begin
                cycle(1'b1, pick_cmd(), 1'b0);
            end else begin
                cycle(1'b0, 8'h00, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
